// File: rtl/vote_tally_tx_pkg.sv
// Shared constants, state encoding and checksum helper for the tally
// read-out path.
package vote_tx_pkg;

    localparam logic [7:0]  PKT_HEADER = 8'hA5;
    localparam int unsigned PKT_BYTES  = 6;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    function automatic logic [7:0] tally_checksum(
        input logic [7:0] c1,
        input logic [7:0] c2,
        input logic [7:0] c3,
        input logic [7:0] c4
    );
        return c1 ^ c2 ^ c3 ^ c4;
    endfunction

endpackage

// File: rtl/vote_tally_tx_if.sv
// Request, tally and serial-output signals of the tally read-out block.
interface vote_tally_tx_if;

    logic       mode;
    logic       send;
    logic [7:0] cand1_votes;
    logic [7:0] cand2_votes;
    logic [7:0] cand3_votes;
    logic [7:0] cand4_votes;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output mode, send, cand1_votes, cand2_votes, cand3_votes, cand4_votes,
        input  tx, busy, done
    );

    modport slave (
        input  mode, send, cand1_votes, cand2_votes, cand3_votes, cand4_votes,
        output tx, busy, done
    );

endinterface

// File: rtl/vote_tally_tx_uart.sv
// Single-byte 8N1 serializer, LSB first, with a registered line output.
// A new byte offered on the last stop-bit cycle starts without an idle gap.
module uart_byte_tx
    import vote_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx
);

    localparam int unsigned  CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

    tx_state_t     r_state;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_data;
    logic          r_tx;

    tx_state_t     w_state_n;
    logic [CW-1:0] w_clk_cnt_n;
    logic [2:0]    w_bit_idx_n;
    logic [7:0]    w_data_n;
    logic          w_tx_n;
    logic          w_bit_end;
    logic [2:0]    w_next_bit;

    assign w_bit_end  = (r_clk_cnt == LAST_CLK);
    assign w_next_bit = r_bit_idx + 3'd1;

    always_comb begin
        w_state_n   = r_state;
        w_clk_cnt_n = r_clk_cnt + CW'(1);
        w_bit_idx_n = r_bit_idx;
        w_data_n    = r_data;
        w_tx_n      = r_tx;
        byte_ready  = 1'b0;

        case (r_state)
            IDLE: begin
                byte_ready  = 1'b1;
                w_clk_cnt_n = '0;
                w_tx_n      = 1'b1;
                if (byte_valid) begin
                    w_state_n   = START;
                    w_data_n    = byte_data;
                    w_bit_idx_n = '0;
                    w_tx_n      = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_n   = DATA;
                    w_clk_cnt_n = '0;
                    w_bit_idx_n = '0;
                    w_tx_n      = r_data[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_clk_cnt_n = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_n = STOP;
                        w_tx_n    = 1'b1;
                    end else begin
                        w_bit_idx_n = w_next_bit;
                        w_tx_n      = r_data[w_next_bit];
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    // Last stop-bit cycle: accept a follow-on byte directly into START.
                    byte_ready  = 1'b1;
                    w_clk_cnt_n = '0;
                    if (byte_valid) begin
                        w_state_n   = START;
                        w_data_n    = byte_data;
                        w_bit_idx_n = '0;
                        w_tx_n      = 1'b0;
                    end else begin
                        w_state_n = IDLE;
                        w_tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_n   = IDLE;
                w_clk_cnt_n = '0;
                w_tx_n      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_data    <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_n;
            r_clk_cnt <= w_clk_cnt_n;
            r_bit_idx <= w_bit_idx_n;
            r_data    <= w_data_n;
            r_tx      <= w_tx_n;
        end
    end

    assign tx = r_tx;

endmodule

// File: rtl/vote_tally_tx.sv
// Snapshots the four candidate tallies in result mode and streams them as
// A5, c1..c4, checksum over a contiguous 8N1 serial line.
module vote_tally_tx
    import vote_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic            clock,
    input  logic            reset,
    vote_tally_tx_if.slave  bus
);

    localparam logic [2:0] LAST_BYTE = 3'(PKT_BYTES - 1);

    logic [7:0] r_snap [4];
    logic [7:0] r_chk;
    logic [2:0] r_byte_idx;
    logic       r_busy;
    logic       r_done;

    logic       w_accept;
    logic       w_byte_ready;
    logic       w_byte_end;
    logic       w_last_byte;
    logic       w_byte_valid;
    logic [7:0] w_byte_data;
    logic [2:0] w_next_idx;

    assign w_accept    = !r_busy && bus.send && bus.mode;
    assign w_byte_end  = r_busy && w_byte_ready;
    assign w_last_byte = (r_byte_idx == LAST_BYTE);
    assign w_next_idx  = r_byte_idx + 3'd1;

    // The header goes out on acceptance itself; later bytes come from the
    // snapshot, offered on the serializer's final stop-bit cycle.
    always_comb begin
        w_byte_valid = 1'b0;
        w_byte_data  = PKT_HEADER;
        if (w_accept) begin
            w_byte_valid = 1'b1;
        end else if (w_byte_end && !w_last_byte) begin
            w_byte_valid = 1'b1;
            case (w_next_idx)
                3'd1:    w_byte_data = r_snap[0];
                3'd2:    w_byte_data = r_snap[1];
                3'd3:    w_byte_data = r_snap[2];
                3'd4:    w_byte_data = r_snap[3];
                3'd5:    w_byte_data = r_chk;
                default: w_byte_data = PKT_HEADER;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_snap     <= '{default: '0};
            r_chk      <= '0;
            r_byte_idx <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_snap     <= '{bus.cand1_votes, bus.cand2_votes,
                                bus.cand3_votes, bus.cand4_votes};
                r_chk      <= tally_checksum(bus.cand1_votes, bus.cand2_votes,
                                             bus.cand3_votes, bus.cand4_votes);
                r_byte_idx <= '0;
                r_busy     <= 1'b1;
            end else if (w_byte_end) begin
                if (w_last_byte) begin
                    r_byte_idx <= '0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                end else begin
                    r_byte_idx <= w_next_idx;
                end
            end
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .clock      (clock),
        .reset      (reset),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .byte_ready (w_byte_ready),
        .tx         (bus.tx)
    );

    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_vote_tally_tx.sv
// Directed bench for vote_tally_tx: a packet-level model predicts tx/busy/done
// every cycle, and decoded packets are pinned against hand-computed bytes.
module tb_vote_tally_tx;

    localparam int C       = 4;
    localparam int PKT_CYC = 60 * C;
    localparam int LOG_N   = 4096;

    logic clk = 1'b0;
    logic rst_n;

    vote_tally_tx_if bus();

    vote_tally_tx #(
        .CLKS_PER_BIT (C)
    ) u_dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;
    int   txlow_cnt = 0;
    logic tx_log [0:LOG_N-1];

    // Packet model: acceptance cycle and the 60 line bits of the current packet
    bit   m_active = 1'b0;
    int   m_N = 0;
    bit   m_bits [0:59];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        logic [7:0] b [0:5];
        cyc = cyc + 1;
        if (rst_n !== 1'b1) begin
            m_active = 1'b0;
        end else if ((!m_active || cyc > m_N + PKT_CYC) &&
                     bus.send === 1'b1 && bus.mode === 1'b1) begin
            b[0] = 8'hA5;
            b[1] = bus.cand1_votes;
            b[2] = bus.cand2_votes;
            b[3] = bus.cand3_votes;
            b[4] = bus.cand4_votes;
            b[5] = b[1] ^ b[2] ^ b[3] ^ b[4];
            for (int i = 0; i < 6; i++) begin
                m_bits[i*10] = 1'b0;
                for (int j = 0; j < 8; j++) m_bits[i*10+1+j] = b[i][j];
                m_bits[i*10+9] = 1'b1;
            end
            m_active = 1'b1;
            m_N      = cyc;
        end
    end

    always @(negedge clk) begin
        logic e_tx, e_busy, e_done;
        if (cyc >= 1) begin
            e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
            if (m_active && cyc < m_N + PKT_CYC) begin
                e_busy = 1'b1;
                e_tx   = m_bits[(cyc - m_N) / C];
            end else if (m_active && cyc == m_N + PKT_CYC) begin
                e_done = 1'b1;
            end
            if (cyc < LOG_N) tx_log[cyc] = bus.tx;
            check("tx", {31'd0, bus.tx}, {31'd0, e_tx});
            check("busy", {31'd0, bus.busy}, {31'd0, e_busy});
            check("done", {31'd0, bus.done}, {31'd0, e_done});
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) done_cnt++;
            if (bus.tx === 1'b0) txlow_cnt++;
        end
    end

    function automatic logic [7:0] dec(input int n, input int b);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = tx_log[n + (b*10 + 1 + i)*C + C/2];
        return v;
    endfunction

    task automatic check_pkt(input string nm, input int n, input logic [47:0] exp);
        for (int b = 0; b < 6; b++)
            check($sformatf("%s_byte%0d", nm, b), {24'd0, dec(n, b)}, {24'd0, exp[47-8*b -: 8]});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_t(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        bus.cand1_votes = a; bus.cand2_votes = b; bus.cand3_votes = c; bus.cand4_votes = d;
    endtask

    task automatic send_pulse(output int acc);
        bus.send = 1'b1;
        acc = cyc + 1;
        tick(1);
        bus.send = 1'b0;
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int k = 0; k < 400; k++) begin
            tick(1);
            if (bus.done === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic clear_counts();
        busy_cnt = 0; done_cnt = 0; txlow_cnt = 0;
    endtask

    initial begin
        int acc, at, acc1, at1, acc2, at2;

        #100000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, at, acc1, at1, acc2, at2;

        rst_n = 1'b0;
        bus.mode = 1'b1;
        bus.send = 1'b1;
        set_t(8'd3, 8'd0, 8'd7, 8'd255);
        tick(3);
        check("rst_tx", {31'd0, bus.tx}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        rst_n = 1'b1;
        bus.send = 1'b0;
        tick(2);
        check("post_rst_tx", {31'd0, bus.tx}, 32'd1);
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);

        // Single packet
        clear_counts();
        send_pulse(acc);
        check("single_accept", m_N, acc);
        check("single_start_bit", {31'd0, bus.tx}, 32'd0);
        check("single_busy_on", {31'd0, bus.busy}, 32'd1);
        wait_done(at);
        check("single_done_cycle", at, acc + 240);
        check("single_busy_cycles", busy_cnt, 240);
        tick(1);
        check("single_done_pulses", done_cnt, 1);
        check_pkt("single", acc, 48'hA5_03_00_07_FF_FB);
        tick(4);

        // Mode gating
        bus.mode = 1'b0;
        bus.send = 1'b1;
        clear_counts();
        tick(20);
        bus.send = 1'b0;
        check("gate_busy_cycles", busy_cnt, 0);
        check("gate_tx_low_cycles", txlow_cnt, 0);

        // Snapshot and busy lockout
        bus.mode = 1'b1;
        set_t(8'd1, 8'd2, 8'd3, 8'd4);
        send_pulse(acc);
        tick(49);
        set_t(8'd9, 8'd9, 8'd9, 8'd9);
        bus.send = 1'b1;
        tick(1);
        bus.send = 1'b0;
        wait_done(at);
        check("snap_done_cycle", at, acc + 240);
        check_pkt("snap", acc, 48'hA5_01_02_03_04_04);
        tick(1);
        clear_counts();
        tick(60);
        check("snap_no_second_busy", busy_cnt, 0);
        check("snap_no_second_tx", txlow_cnt, 0);

        // Back-to-back
        set_t(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        send_pulse(acc1);
        wait_done(at1);
        check("b2b_done1_cycle", at1, acc1 + 240);
        set_t(8'h10, 8'h20, 8'h30, 8'h40);
        bus.send = 1'b1;
        acc2 = cyc + 1;
        tick(1);
        bus.send = 1'b0;
        check("b2b_accept", m_N, acc2);
        check("b2b_start_bit", {31'd0, bus.tx}, 32'd0);
        check("b2b_busy", {31'd0, bus.busy}, 32'd1);
        wait_done(at2);
        check("b2b_done2_cycle", at2, acc2 + 240);
        check_pkt("b2b_first", acc1, 48'hA5_FF_FF_FF_FF_00);
        check_pkt("b2b_second", acc2, 48'hA5_10_20_30_40_40);
        tick(2);

        // Reset mid-packet: byte 2 is 0x00, so the line would be low at cycle 100
        set_t(8'hC3, 8'h00, 8'h3C, 8'h5A);
        send_pulse(acc);
        tick(99);
        rst_n = 1'b0;
        tick(1);
        check("midrst_tx", {31'd0, bus.tx}, 32'd1);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        rst_n = 1'b1;
        tick(2);
        set_t(8'h12, 8'h34, 8'h56, 8'h78);
        send_pulse(acc);
        wait_done(at);
        check("after_rst_done_cycle", at, acc + 240);
        check_pkt("after_rst", acc, 48'hA5_12_34_56_78_08);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
